// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request in, WAIT_CYCLES wait states, registered response out.
// Optional range checking of the word index is enabled by defining MEM_RANGE_CHECK_EN.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned MEM_SIZE    = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IdxW  = ADDR_WIDTH - 1;
    localparam int unsigned MemAw = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [MemAw-1:0]      mem_idx;
    logic                  out_of_range;
    logic                  commit;
    logic                  mem_we;
    logic                  unused_bits;

    assign mem_idx = idx_q[MemAw-1:0];

`ifdef MEM_RANGE_CHECK_EN
    assign out_of_range = (32'(idx_q) >= MEM_SIZE);
`else
    assign out_of_range = 1'b0;
`endif

    // The access commits on the edge that leaves the final wait cycle and enters StResp.
    assign commit = (state_q == StWait) && (cnt_q == 8'd0);
    assign mem_we = commit && wr_q && !out_of_range;

    assign unused_bits = ^{req_addr[0], idx_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    wr_d        = req_wr;
                    idx_d       = req_addr[ADDR_WIDTH-1:1];
                    wdata_d     = req_wdata;
                    // StWait is always visited once, so latency is WAIT_CYCLES+1 edges even for 0.
                    cnt_d       = 8'(WAIT_CYCLES);
                    state_d     = StWait;
                    req_ready_d = 1'b0;
                end
            end
            StWait: begin
                if (cnt_q == 8'd0) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (wr_q || out_of_range) ? '0 : mem[mem_idx];
                    rsp_err_d   = out_of_range;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus random traffic against a word-array model.
// Expectations follow MEM_RANGE_CHECK_EN when it is defined for the build.
module tb_data_mem_responder;

    localparam int unsigned W  = 2;
    localparam int unsigned MS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
    logic [15:0] req_addr, req_wdata, rsp_rdata;
    logic        z_req_valid, z_req_ready, z_req_wr, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [15:0] z_req_addr, z_req_wdata, z_rsp_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem_m [MS];

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .MEM_SIZE   (MS),
        .WAIT_CYCLES(W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    data_mem_responder #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .MEM_SIZE   (MS),
        .WAIT_CYCLES(0)
    ) u_dut_z (
        .clk      (clk),
        .rst      (rst),
        .req_valid(z_req_valid),
        .req_ready(z_req_ready),
        .req_wr   (z_req_wr),
        .req_addr (z_req_addr),
        .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid),
        .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata),
        .rsp_err  (z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance; called #1 after an edge with DUT idle.
    task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input int hold);
        int          idx;
        int          slot;
        logic        oor;
        logic [15:0] exp_d;
        idx  = int'(addr[15:1]);
        slot = idx % MS;
`ifdef MEM_RANGE_CHECK_EN
        oor = (idx >= MS);
`else
        oor = 1'b0;
`endif
        exp_d = (wr || oor) ? 16'h0 : mem_m[slot];
        check("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_wr    = 1'(~wr);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        check("accept_req_ready", 32'(req_ready), 32'd0);
        for (int k = 1; k <= int'(W); k++) begin
            tick();
            check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
        check("rsp_err", 32'(rsp_err), 32'(oor));
        if (wr && !oor) mem_m[slot] = wd;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("done_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("done_rsp_err", 32'(rsp_err), 32'd0);
        check("done_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_wr      = 1'b0;
        req_addr    = 16'h0;
        req_wdata   = 16'h0;
        rsp_ready   = 1'b0;
        z_req_valid = 1'b0;
        z_req_wr    = 1'b0;
        z_req_addr  = 16'h0;
        z_req_wdata = 16'h0;
        z_rsp_ready = 1'b0;
        for (int i = 0; i < int'(MS); i++) mem_m[i] = 16'h0;

        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        check("rel_req_ready", 32'(req_ready), 32'd0);
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_z_req_ready", 32'(z_req_ready), 32'd1);

        // Write then read back, and a read with a stalled requester.
        xact(1'b1, 16'h0010, 16'h1234, 0);
        xact(1'b0, 16'h0010, 16'h0000, 0);
        xact(1'b0, 16'h0010, 16'h0000, 5);

        // Pending write dropped by reset during the wait phase.
        xact(1'b1, 16'h0020, 16'hAAAA, 0);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'h5555;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("midrst_rsp_valid2", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_rel_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        xact(1'b0, 16'h0020, 16'h0000, 1);

        // Out-of-range index: flagged with the range check, aliased without it.
        xact(1'b1, 16'h0000, 16'h1111, 0);
        xact(1'b1, 16'h0200, 16'hBEEF, 0);
        xact(1'b0, 16'h0000, 16'h0000, 0);

        // Zero-wait instance: response one edge after accept, back-to-back reads.
        z_rsp_ready = 1'b1;
        z_req_valid = 1'b1;
        z_req_wr    = 1'b1;
        z_req_addr  = 16'h0004;
        z_req_wdata = 16'h4321;
        tick();
        z_req_valid = 1'b0;
        check("z_accept_req_ready", 32'(z_req_ready), 32'd0);
        tick();
        check("z_wr_rsp_valid", 32'(z_rsp_valid), 32'd1);
        check("z_wr_rsp_rdata", 32'(z_rsp_rdata), 32'd0);
        z_req_valid = 1'b1;
        z_req_wr    = 1'b0;
        tick();
        check("z_done_rsp_valid", 32'(z_rsp_valid), 32'd0);
        check("z_done_req_ready", 32'(z_req_ready), 32'd1);
        tick();
        z_req_valid = 1'b0;
        check("z_rd_accept_req_ready", 32'(z_req_ready), 32'd0);
        tick();
        check("z_rd_rsp_valid", 32'(z_rsp_valid), 32'd1);
        check("z_rd_rsp_rdata", 32'(z_rsp_rdata), 32'h4321);
        check("z_rd_rsp_err", 32'(z_rsp_err), 32'd0);
        tick();
        check("z_rd_done_req_ready", 32'(z_req_ready), 32'd1);
        z_rsp_ready = 1'b0;

        // Random traffic over 32 known words plus their aliases above MEM_SIZE.
        for (int i = 0; i < 32; i++) begin
            a = 16'(i * 2) | 16'($urandom_range(0, 1));
            xact(1'b1, a, 16'($urandom), 0);
        end
        for (int i = 0; i < 40; i++) begin
            a = 16'(($urandom_range(0, 31) + (($urandom_range(0, 3) == 0) ? 256 : 0)) * 2);
            a = a | 16'($urandom_range(0, 1));
            xact(1'($urandom_range(0, 1)), a, 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
